pong_merge: RTL and testbench
=============================

PONG_MERGE -- requirements
Module: pong_merge

Interface
REQ-001 SHALL have parameter WIDTH, default 704, the message width: a[31:0], b[63:32], c = 20 x 32-bit words [703:64].
REQ-002 SHALL have parameter DEPTH, default 2, the entries per lane buffer; legal values are 2 and 4.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in0$enq__ENA  input  1  lane-0 enqueue strobe.
REQ-006 SHALL have port in0$enq$v  input  WIDTH  lane-0 message.
REQ-007 SHALL have port in0$enq__RDY  output  1  lane 0 can accept.
REQ-008 SHALL have ports in1$enq__ENA / in1$enq$v / in1$enq__RDY with the same widths and meanings, for lane 1.
REQ-009 SHALL have port out$first  output  WIDTH  head message of the currently selected lane.
REQ-010 SHALL have port out$first__RDY  output  1  out$first is valid.
REQ-011 SHALL have port out$deq__ENA  input  1  consumer dequeue strobe.
REQ-012 SHALL have port out$deq__RDY  output  1  a dequeue is legal.
REQ-013 SHALL have port sel  output  1  index of the lane that supplies the next output message.

Function
REQ-014 SHALL reassemble the stream split by the ping-pong enqueue: outputs are taken strictly lane0, lane1, lane0, ... regardless of arrival order.
REQ-015 SHALL give each lane a DEPTH-entry FIFO with a write pointer, a read pointer, and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 SHALL drive ink$enq__RDY = (count_k < DEPTH); an enqueue fires when ENA && RDY, and ENA without RDY is ignored with no state change.
REQ-017 SHALL drive out$first__RDY = out$deq__RDY = (count of lane[sel] != 0), with no dependence on the other lane.
REQ-018 SHALL drive out$first as the head of lane[sel] when out$first__RDY is 1, and all zeros otherwise.
REQ-019 SHALL, on a dequeue (out$deq__ENA && out$deq__RDY), advance lane[sel]'s read pointer, decrement its count, and toggle sel, all in the same edge.
REQ-020 SHALL, on a simultaneous enqueue and dequeue on the same lane, leave count unchanged and advance both pointers; with count = DEPTH, RDY is already 0 and there is no bypass.
REQ-021 SHALL make data latency from enqueue to out$first 1 cycle; an enqueue into an empty selected lane makes out$first__RDY 1 in the next cycle.
REQ-022 SHALL hold sel while lane[sel] is empty, even if the other lane is full; this stall is required behaviour, not a deadlock.
REQ-023 SHALL support full throughput of 1 dequeue per cycle when both lanes hold at least 1 entry.
REQ-024 SHALL keep ENA, RDY and data paths free of combinational paths from any ENA to any RDY.

Reset
REQ-025 SHALL, while RST = 1, immediately force sel = 0, all pointers and counts = 0, in0$enq__RDY = in1$enq__RDY = 1, out$first__RDY = out$deq__RDY = 0, and out$first = 0.
REQ-026 SHALL discard buffered messages on a reset asserted mid-operation; the first message after release comes from lane 0.
REQ-027 SHALL leave storage arrays unreset; only control state is reset.

Structure
REQ-028 SHALL take the message field offsets, the 20-word count and WIDTH = 704 from the shared echo message package.
REQ-029 SHALL instantiate one sub-module, Fifo2Base (parameters WIDTH and DEPTH, enq/deq/first interface), once per lane; pong_merge adds the sel state and the output multiplexing.

Verification
REQ-030 SHALL cover: after reset, enq lane1 a=0x11 then lane0 a=0x22 -> output order 0x22 then 0x11, sel toggling 0->1->0.
REQ-031 SHALL cover: fill lane1 with DEPTH=2 messages while lane0 is empty -> in1$enq__RDY = 0 and out$first__RDY = 0; one lane0 enq then releases 3 dequeues in order L0, L1, L0 is blocked.
REQ-032 SHALL cover: both lanes continuously fed, out$deq__ENA held at 1 -> one dequeue per cycle for 100 cycles with a, b and c[19] sequence-checked.
REQ-033 SHALL cover: lane0 count = 1 with simultaneous enq and deq on lane0 -> count stays 1 and the new head equals the enqueued value.
REQ-034 SHALL cover: RST pulsed with both lanes full -> all RDY and sel values per REQ-025 within the same cycle, and no stale data output afterwards.
REQ-035 SHALL cover: ENA asserted while RDY = 0 on any port -> no pointer or count change.

Source files
------------

// File: rtl/pong_merge_pkg.sv
// rtl/pong_merge_pkg.sv - shared echo message layout: field offsets, word count and message width
package pong_merge_pkg;

    localparam int WORD_W    = 32;
    localparam int C_WORDS   = 20;
    localparam int A_LSB     = 0;
    localparam int B_LSB     = 32;
    localparam int C_LSB     = 64;
    localparam int MSG_WIDTH = C_LSB + C_WORDS * WORD_W;

    typedef logic [MSG_WIDTH-1:0] msg_t;
    typedef logic [WORD_W-1:0]    word_t;

    // c words are filled with an incrementing pattern so every word is distinguishable
    function automatic msg_t msg_pack(input word_t a, input word_t b, input word_t c_base);
        msg_t m;
        m = '0;
        m[A_LSB +: WORD_W] = a;
        m[B_LSB +: WORD_W] = b;
        for (int k = 0; k < C_WORDS; k++) begin
            m[C_LSB + k*WORD_W +: WORD_W] = c_base + word_t'(k);
        end
        return m;
    endfunction

    function automatic word_t msg_c_word(input msg_t m, input int k);
        return m[C_LSB + k*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/pong_merge_fifo2base.sv
// rtl/pong_merge_fifo2base.sv - per-lane DEPTH-entry FIFO with enq/deq/first interface
module Fifo2Base
    import pong_merge_pkg::*;
#(
    parameter int WIDTH = MSG_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    output logic             enq__RDY,
    input  logic             deq__ENA,
    output logic             deq__RDY,
    output logic [WIDTH-1:0] first,
    output logic             first__RDY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             enq_fire;
    logic             deq_fire;

    // RDY depends on registered count only, so no ENA-to-RDY path exists
    assign enq__RDY   = (count < CNT_W'(DEPTH));
    assign deq__RDY   = (count != '0);
    assign first__RDY = deq__RDY;
    assign first      = mem[rptr];

    assign enq_fire = enq__ENA && enq__RDY;
    assign deq_fire = deq__ENA && deq__RDY;

    always_ff @(posedge CLK) begin
        if (enq_fire) begin
            mem[wptr] <= enq_v;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                wptr <= wptr + 1'b1;
            end
            if (deq_fire) begin
                rptr <= rptr + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pong_merge.sv
// rtl/pong_merge.sv - reassembles a ping-pong split stream, strictly alternating lane 0 and lane 1
module pong_merge
    import pong_merge_pkg::*;
#(
    parameter int WIDTH = MSG_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic             sel
);

    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic             head_rdy0;
    logic             head_rdy1;
    logic             deq_rdy0;
    logic             deq_rdy1;
    logic             deq_fire;

    Fifo2Base #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
        .CLK        (CLK),
        .RST        (RST),
        .enq__ENA   (in0_enq__ENA),
        .enq_v      (in0_enq_v),
        .enq__RDY   (in0_enq__RDY),
        .deq__ENA   (deq_fire && !sel),
        .deq__RDY   (deq_rdy0),
        .first      (head0),
        .first__RDY (head_rdy0)
    );

    Fifo2Base #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
        .CLK        (CLK),
        .RST        (RST),
        .enq__ENA   (in1_enq__ENA),
        .enq_v      (in1_enq_v),
        .enq__RDY   (in1_enq__RDY),
        .deq__ENA   (deq_fire && sel),
        .deq__RDY   (deq_rdy1),
        .first      (head1),
        .first__RDY (head_rdy1)
    );

    // Only the selected lane matters; a full other lane must not advance sel
    assign out_first__RDY = sel ? head_rdy1 : head_rdy0;
    assign out_deq__RDY   = sel ? deq_rdy1 : deq_rdy0;
    assign out_first      = out_first__RDY ? (sel ? head1 : head0) : '0;
    assign deq_fire       = out_deq__ENA && out_deq__RDY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel <= 1'b0;
        end else if (deq_fire) begin
            sel <= ~sel;
        end
    end

endmodule

// File: tb/tb_pong_merge.sv
// tb/tb_pong_merge.sv - directed scoreboard bench for pong_merge
module tb_pong_merge;
    import pong_merge_pkg::*;

    localparam int W     = MSG_WIDTH;
    localparam int DEPTH = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in0_enq__ENA = 1'b0;
    logic [W-1:0] in0_enq_v = '0;
    logic         in0_enq__RDY;
    logic         in1_enq__ENA = 1'b0;
    logic [W-1:0] in1_enq_v = '0;
    logic         in1_enq__RDY;
    logic [W-1:0] out_first;
    logic         out_first__RDY;
    logic         out_deq__ENA = 1'b0;
    logic         out_deq__RDY;
    logic         sel;

    msg_t q0[$];
    msg_t q1[$];
    logic msel = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic fired_enq0, fired_enq1, fired_deq;
    int   deq_count;
    word_t seq0, seq1;

    pong_merge #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .in0_enq__ENA   (in0_enq__ENA),
        .in0_enq_v      (in0_enq_v),
        .in0_enq__RDY   (in0_enq__RDY),
        .in1_enq__ENA   (in1_enq__ENA),
        .in1_enq_v      (in1_enq_v),
        .in1_enq__RDY   (in1_enq__RDY),
        .out_first      (out_first),
        .out_first__RDY (out_first__RDY),
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .sel            (sel)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input msg_t obs, input msg_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".in0_rdy"}, msg_t'(in0_enq__RDY), msg_t'(1'b1));
        chk({tag, ".in1_rdy"}, msg_t'(in1_enq__RDY), msg_t'(1'b1));
        chk({tag, ".first_rdy"}, msg_t'(out_first__RDY), msg_t'(1'b0));
        chk({tag, ".deq_rdy"}, msg_t'(out_deq__RDY), msg_t'(1'b0));
        chk({tag, ".sel"}, msg_t'(sel), msg_t'(1'b0));
        chk({tag, ".first"}, out_first, '0);
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance the model
    task automatic step(input string tag, input logic e0, input msg_t v0,
                        input logic e1, input msg_t v1, input logic d);
        logic r0, r1, fr;
        msg_t ef;
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        fr = msel ? (q1.size() != 0) : (q0.size() != 0);
        ef = '0;
        if (fr) ef = msel ? q1[0] : q0[0];
        in0_enq__ENA = e0; in0_enq_v = v0;
        in1_enq__ENA = e1; in1_enq_v = v1;
        out_deq__ENA = d;
        #1;
        chk({tag, ".in0_rdy"}, msg_t'(in0_enq__RDY), msg_t'(r0));
        chk({tag, ".in1_rdy"}, msg_t'(in1_enq__RDY), msg_t'(r1));
        chk({tag, ".first_rdy"}, msg_t'(out_first__RDY), msg_t'(fr));
        chk({tag, ".deq_rdy"}, msg_t'(out_deq__RDY), msg_t'(fr));
        chk({tag, ".sel"}, msg_t'(sel), msg_t'(msel));
        chk({tag, ".first"}, out_first, ef);
        @(posedge CLK);
        #1;
        fired_deq  = d && fr;
        fired_enq0 = e0 && r0;
        fired_enq1 = e1 && r1;
        if (fired_deq) begin
            if (msel) void'(q1.pop_front());
            else      void'(q0.pop_front());
            msel = ~msel;
        end
        if (fired_enq0) q0.push_back(v0);
        if (fired_enq1) q1.push_back(v1);
        in0_enq__ENA = 1'b0;
        in1_enq__ENA = 1'b0;
        out_deq__ENA = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Reset raised between edges: outputs must change without waiting for a clock
    task automatic pulse_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_outputs(tag);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        q0.delete();
        q1.delete();
        msel = 1'b0;
    endtask

    initial begin
        #2;
        chk_reset_outputs("por");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Arrival order lane1 then lane0; output still lane0 first
        step("ord_enq1", 1'b0, '0, 1'b1, msg_pack(32'h11, 32'h1, 32'h100), 1'b0);
        step("ord_enq0", 1'b1, msg_pack(32'h22, 32'h2, 32'h200), 1'b0, '0, 1'b0);
        chk("ord_head", msg_t'(out_first[A_LSB +: WORD_W]), msg_t'(32'h22));
        step("ord_deq0", 1'b0, '0, 1'b0, '0, 1'b1);
        chk("ord_head2", msg_t'(out_first[A_LSB +: WORD_W]), msg_t'(32'h11));
        step("ord_deq1", 1'b0, '0, 1'b0, '0, 1'b1);
        idle("ord_empty");

        // Lane1 full while lane0 empty: stall, ignored ENA/deq with RDY low
        step("stall_f1a", 1'b0, '0, 1'b1, msg_pack(32'h31, 32'h3, 32'h300), 1'b0);
        step("stall_f1b", 1'b0, '0, 1'b1, msg_pack(32'h32, 32'h3, 32'h310), 1'b0);
        step("stall_ign", 1'b0, '0, 1'b1, msg_pack(32'hBAD, 32'hBAD, 32'hBAD), 1'b1);
        step("stall_ign2", 1'b0, '0, 1'b1, msg_pack(32'hBAD, 32'hBAD, 32'hBAD), 1'b1);
        step("stall_e0", 1'b1, msg_pack(32'h41, 32'h4, 32'h400), 1'b0, '0, 1'b0);
        step("stall_d1", 1'b0, '0, 1'b0, '0, 1'b1);
        step("stall_d2", 1'b0, '0, 1'b0, '0, 1'b1);
        step("stall_d3", 1'b0, '0, 1'b0, '0, 1'b1);
        step("stall_e0b", 1'b1, msg_pack(32'h42, 32'h4, 32'h410), 1'b0, '0, 1'b0);
        step("stall_d4", 1'b0, '0, 1'b0, '0, 1'b1);
        step("stall_d5", 1'b0, '0, 1'b0, '0, 1'b1);
        idle("stall_empty");

        // Lane0 at count 1: simultaneous enq and deq keeps one entry with the new head
        step("sim_e0", 1'b1, msg_pack(32'h51, 32'h5, 32'h500), 1'b0, '0, 1'b0);
        step("sim_both", 1'b1, msg_pack(32'h52, 32'h5, 32'h510), 1'b1,
             msg_pack(32'h61, 32'h6, 32'h600), 1'b1);
        step("sim_d1", 1'b0, '0, 1'b0, '0, 1'b1);
        chk("sim_head", out_first, msg_pack(32'h52, 32'h5, 32'h510));
        step("sim_d0", 1'b0, '0, 1'b0, '0, 1'b1);
        idle("sim_empty");

        // Full throughput: both lanes fed, deq held high
        pulse_reset("rst_tp");
        seq0 = 0;
        seq1 = 0;
        step("tp_prime", 1'b1, msg_pack(seq0 * 2, ~(seq0 * 2), seq0 * 64), 1'b1,
             msg_pack(seq1 * 2 + 1, ~(seq1 * 2 + 1), seq1 * 64 + 32), 1'b0);
        seq0++;
        seq1++;
        deq_count = 0;
        for (int i = 0; i < 100; i++) begin
            step("tp", 1'b1, msg_pack(seq0 * 2, ~(seq0 * 2), seq0 * 64), 1'b1,
                 msg_pack(seq1 * 2 + 1, ~(seq1 * 2 + 1), seq1 * 64 + 32), 1'b1);
            if (fired_enq0) seq0++;
            if (fired_enq1) seq1++;
            if (fired_deq) deq_count++;
        end
        chk("tp_count", msg_t'(deq_count), msg_t'(100));
        chk("tp_c19", msg_t'(msg_c_word(out_first, C_WORDS - 1)), msg_t'(msg_c_word(q0[0], C_WORDS - 1)));

        // Both lanes full, then reset: no stale data afterwards
        while (q0.size() < DEPTH || q1.size() < DEPTH)
            step("full_fill", 1'b1, msg_pack(32'h71, 32'h7, 32'h700), 1'b1,
                 msg_pack(32'h72, 32'h7, 32'h710), 1'b0);
        pulse_reset("rst_full");
        idle("post_rst_idle");
        step("post_e1", 1'b0, '0, 1'b1, msg_pack(32'h81, 32'h8, 32'h800), 1'b0);
        step("post_e0", 1'b1, msg_pack(32'h82, 32'h8, 32'h810), 1'b0, '0, 1'b0);
        step("post_d0", 1'b0, '0, 1'b0, '0, 1'b1);
        step("post_d1", 1'b0, '0, 1'b0, '0, 1'b1);
        idle("post_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
